// File: rtl/smac_pkg.sv
// Shared definitions for the bit-serial MAC weight path.
//   par_sel_t   runtime precision selector (Pw/2, Pw-2, Pw; 2'b11 also means Pw)
//   ser_state_t serializer FSM state
//   prec_bits() decodes a selector into the number of serial bits per word
package smac_pkg;

    typedef enum logic [1:0] {
        PAR_HALF = 2'b00,
        PAR_M2   = 2'b01,
        PAR_FULL = 2'b10
    } par_sel_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Number of bits per word at the selected precision; 2'b11 falls through to Pw.
    function automatic int unsigned prec_bits(input par_sel_t sel, input int unsigned pw);
        case (sel)
            PAR_HALF: prec_bits = pw / 2;
            PAR_M2:   prec_bits = pw - 2;
            default:  prec_bits = pw;
        endcase
    endfunction

endpackage

// File: rtl/weight_bit_serializer_shadow_buf.sv
// ser_shadow_buf: one-entry holding register in front of the serializer shift register.
// Keeps the next weight word and the precision selector seen when it was accepted, so the
// serializer can move it into the shift register on the last bit of the active word.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush (empties the entry)
//   push         write push_data/push_sel (entry becomes full)
//   pop          entry consumed by the serializer (entry becomes empty)
//   full         entry holds a word
//   data, sel    stored word and its precision selector
module ser_shadow_buf
    import smac_pkg::*;
#(
    parameter int Pw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [Pw-1:0] push_data,
    input  logic [1:0]    push_sel,
    input  logic          pop,
    output logic          full,
    output logic [Pw-1:0] data,
    output logic [1:0]    sel
);

    logic          full_q, full_d;
    logic [Pw-1:0] data_q, data_d;
    logic [1:0]    sel_q,  sel_d;

    // NOTE: every signal assigned in always_comb gets a default first; a missing branch would
    // otherwise infer a latch.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        sel_d  = sel_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (push) begin
            full_d = 1'b1;
            data_d = push_data;
            sel_d  = push_sel;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // NOTE: the payload needs no reset; full_q qualifies it, so leaving it reset-free
    // keeps the data path free of reset fanout.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        sel_q  <= sel_d;
    end

    assign full = full_q;
    assign data = data_q;
    assign sel  = sel_q;

endmodule

// File: rtl/weight_bit_serializer.sv
// weight_bit_serializer: transmit side of the bit-serial weight path. Accepts Pw-bit weights
// over valid/ready and emits them LSB-first, one bit per clock, at the precision chosen by
// par_sel_Pw when the word enters the shift register. A one-word shadow buffer keeps
// back-to-back words gapless.
//   clk, rst_n      clock, asynchronous active-low reset
//   cnt_clear       synchronous flush of active word, shadow word and bit counter
//   par_sel_Pw      precision select: 00 Pw/2, 01 Pw-2, 10/11 Pw
//   w_valid/w_ready weight handshake, w_data two's complement in the low N bits
//   bit_out         current serial bit, bit_valid strobes it
//   bit_last        bit_out is the sign bit (bit N-1); bit_sign is an identical copy
//   busy            active word or shadow word held
module weight_bit_serializer
    import smac_pkg::*;
#(
    parameter int Pw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cnt_clear,
    input  logic [1:0]    par_sel_Pw,
    input  logic          w_valid,
    input  logic [Pw-1:0] w_data,
    output logic          w_ready,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          bit_last,
    output logic          bit_sign,
    output logic          busy
);

    localparam int CW = $clog2(Pw) + 1;

    ser_state_t    state_q, state_d;
    logic [Pw-1:0] sreg_q,  sreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] n_lat_q, n_lat_d;

    logic          shadow_full;
    logic [Pw-1:0] shadow_data;
    logic [1:0]    shadow_sel;

    logic active, at_last, accept, load_direct, push_shadow, pop_shadow;

    assign active  = (state_q == ST_SHIFT);
    assign at_last = active && (cnt_q == n_lat_q - CW'(1));
    assign w_ready = !shadow_full && !cnt_clear;
    assign accept  = w_valid && w_ready;

    // A word bypasses the shadow when the shift register is free at the next edge. With the
    // shadow full w_ready is low, so a shadow move and a direct load never coincide.
    assign load_direct = accept && (!active || at_last);
    assign push_shadow = accept && !load_direct;
    assign pop_shadow  = at_last && shadow_full && !cnt_clear;

    ser_shadow_buf #(.Pw(Pw)) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .push      (push_shadow),
        .push_data (w_data),
        .push_sel  (par_sel_Pw),
        .pop       (pop_shadow),
        .full      (shadow_full),
        .data      (shadow_data),
        .sel       (shadow_sel)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        n_lat_d = n_lat_q;
        if (cnt_clear) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
        end else if (pop_shadow) begin
            state_d = ST_SHIFT;
            sreg_d  = shadow_data;
            cnt_d   = '0;
            n_lat_d = CW'(prec_bits(par_sel_t'(shadow_sel), Pw));
        end else if (load_direct) begin
            state_d = ST_SHIFT;
            sreg_d  = w_data;
            cnt_d   = '0;
            n_lat_d = CW'(prec_bits(par_sel_t'(par_sel_Pw), Pw));
        end else if (at_last) begin
            // Nothing queued: drop to IDLE with a quiet bit_out.
            state_d = ST_IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
        end else if (active) begin
            sreg_d  = sreg_q >> 1;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            n_lat_q <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            n_lat_q <= n_lat_d;
        end
    end

    assign bit_out   = sreg_q[0];
    assign bit_valid = active;
    assign bit_last  = at_last;
    assign bit_sign  = at_last;
    assign busy      = active || shadow_full;

endmodule
